// File: rtl/rng_request_arbiter.sv
// rng_request_arbiter: shares one RNG datapath among NUM_REQ requesters.
// After reset a block of RNG words is thrown away to let the source settle,
// then requests are served one at a time in round-robin order. Each word the
// RNG produces is checked against the previous one; a run of identical words
// latches a permanent health failure that only reset clears.
module rng_request_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int OUTPUT_WIDTH   = 16,
   parameter int WARMUP_WORDS   = 16,
   parameter int REPEAT_LIMIT   = 3,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   output logic [NUM_REQ-1:0]      grant,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [OUTPUT_WIDTH-1:0] rsp_data,
   output logic                    rng_enable,
   input  logic [OUTPUT_WIDTH-1:0] rng_data,
   input  logic                    rng_valid,
   output logic                    busy,
   output logic                    health_fail
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WARM_W = $clog2(WARMUP_WORDS + 1);
   localparam int REP_W  = $clog2(REPEAT_LIMIT + 1);
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

   // Terminal values: the counter holds the count before the current event,
   // so the "last" value is one below the limit.
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_WORDS - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_LIMIT - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      WARMUP  = 3'd0,
      IDLE    = 3'd1,
      ISSUE   = 3'd2,
      WAIT    = 3'd3,
      DELIVER = 3'd4,
      FAIL    = 3'd5
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        grant_idx;
   logic [WARM_W-1:0]       warm_cnt;
   logic [TMR_W-1:0]        wait_tmr;
   logic [REP_W-1:0]        repeat_cnt;
   logic [OUTPUT_WIDTH-1:0] prev_word;
   logic [OUTPUT_WIDTH-1:0] captured;

   logic                    pick_found;
   logic [IDX_W-1:0]        pick_idx;
   logic                    word_match;
   logic                    health_trip;
   logic [REP_W-1:0]        repeat_next;

   // Round-robin search: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      int c;
      pick_found = 1'b0;
      pick_idx   = '0;
      c          = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         c = (int'(rr_ptr) + i) % NUM_REQ;
         if (!pick_found && req[IDX_W'(c)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(c);
         end
      end
   end

   // Repetition test on the incoming word; repeat_cnt of zero means no
   // previous word has been seen yet, so the first word starts a run of one.
   always_comb begin
      word_match  = (repeat_cnt != '0) && (rng_data == prev_word);
      repeat_next = word_match ? repeat_cnt + 1'b1 : REP_W'(1);
      health_trip = word_match && (repeat_cnt >= REP_LAST);
   end

   // Main controller: state and every output are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WARMUP;
         grant       <= '0;
         grant_idx   <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rng_enable  <= 1'b0;
         busy        <= 1'b0;
         health_fail <= 1'b0;
         rr_ptr      <= '0;
         warm_cnt    <= '0;
         wait_tmr    <= '0;
         repeat_cnt  <= '0;
         prev_word   <= '0;
         captured    <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            WARMUP: begin
               rng_enable <= 1'b1;
               busy       <= 1'b1;
               if (rng_valid) begin
                  prev_word  <= rng_data;
                  repeat_cnt <= repeat_next;
                  if (health_trip) begin
                     state       <= FAIL;
                     health_fail <= 1'b1;
                     grant       <= '0;
                     rng_enable  <= 1'b0;
                  end else if (warm_cnt == WARM_LAST) begin
                     state      <= IDLE;
                     rng_enable <= 1'b0;
                     busy       <= 1'b0;
                  end else begin
                     warm_cnt <= warm_cnt + 1'b1;
                  end
               end
            end

            IDLE: begin
               if (pick_found) begin
                  grant      <= NUM_REQ'(1) << pick_idx;
                  grant_idx  <= pick_idx;
                  rng_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end else begin
                  busy <= 1'b0;
               end
            end

            ISSUE: begin
               rng_enable <= 1'b0;
               wait_tmr   <= '0;
               state      <= WAIT;
            end

            WAIT: begin
               if (rng_valid) begin
                  prev_word  <= rng_data;
                  repeat_cnt <= repeat_next;
                  if (health_trip) begin
                     state       <= FAIL;
                     health_fail <= 1'b1;
                     grant       <= '0;
                     rng_enable  <= 1'b0;
                  end else begin
                     captured <= rng_data;
                     state    <= DELIVER;
                  end
               end else if (wait_tmr == TMR_LAST) begin
                  state       <= FAIL;
                  health_fail <= 1'b1;
                  grant       <= '0;
                  rng_enable  <= 1'b0;
               end else begin
                  wait_tmr <= wait_tmr + 1'b1;
               end
            end

            DELIVER: begin
               rsp_valid <= grant;
               rsp_data  <= captured;
               grant     <= '0;
               rr_ptr    <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end

            FAIL: begin
               health_fail <= 1'b1;
               grant       <= '0;
               rng_enable  <= 1'b0;
               busy        <= 1'b1;
            end

            default: begin
               state       <= FAIL;
               health_fail <= 1'b1;
               grant       <= '0;
               rng_enable  <= 1'b0;
               busy        <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed bench for rng_request_arbiter: warmup, single and round-robin
// transactions, repetition failure, wait timeout and asynchronous reset.
module tb_rng_request_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        rng_enable;
   logic [15:0] rng_data;
   logic        rng_valid;
   logic        busy;
   logic        health_fail;

   int checks = 0;
   int errors = 0;

   rng_request_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rng_enable  (rng_enable),
      .rng_data    (rng_data),
      .rng_valid   (rng_valid),
      .busy        (busy),
      .health_fail (health_fail)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it and reports a mismatch
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Assert reset mid-cycle, confirm outputs clear at once, then release
   task automatic apply_reset(input string tag);
      req       = 4'b0000;
      rng_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check_output({tag, "_grant"},  grant,       4'h0);
      check_output({tag, "_rspv"},   rsp_valid,   4'h0);
      check_output({tag, "_rspd"},   rsp_data,    16'h0);
      check_output({tag, "_rngen"},  rng_enable,  1'b0);
      check_output({tag, "_busy"},   busy,        1'b0);
      check_output({tag, "_hfail"},  health_fail, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // First edge after reset release: RNG enabled and block busy
   task automatic start_warmup();
      tick();
      check_output("warm_start_rngen", rng_enable, 1'b1);
      check_output("warm_start_busy",  busy,       1'b1);
   endtask

   // Feed warmup words; rng_enable stays high until the 16th word
   task automatic feed_words(input logic [15:0] base, input int first, input int count);
      for (int i = 0; i < count; i++) begin
         rng_valid = 1'b1;
         rng_data  = base + 16'(first + i);
         tick();
         check_output("warm_rngen", rng_enable, ((first + i) < 15) ? 1'b1 : 1'b0);
         check_output("warm_rspv",  rsp_valid,  4'h0);
      end
      rng_valid = 1'b0;
   endtask

   // Full transaction with req held, RNG answering in the first WAIT cycle
   task automatic transact(input logic [3:0] req_pat, input logic [15:0] word,
                           input logic [3:0] exp_grant, input string tag);
      req = req_pat;
      tick();
      check_output({tag, "_grant"}, grant,      exp_grant);
      check_output({tag, "_rngen"}, rng_enable, 1'b1);
      tick();
      check_output({tag, "_rngen_off"}, rng_enable, 1'b0);
      rng_valid = 1'b1;
      rng_data  = word;
      tick();
      rng_valid = 1'b0;
      check_output({tag, "_rspv_early"}, rsp_valid, 4'h0);
      tick();
      check_output({tag, "_rspv"},  rsp_valid, exp_grant);
      check_output({tag, "_rspd"},  rsp_data,  word);
      check_output({tag, "_gclr"},  grant,     4'h0);
   endtask

   initial begin
      rst_n     = 1'b1;
      req       = 4'b0000;
      rng_data  = 16'h0000;
      rng_valid = 1'b0;
      #2;

      // Reset and full warmup with distinct words
      apply_reset("rst0");
      start_warmup();
      feed_words(16'h1000, 0, 16);
      check_output("warm_done_busy", busy, 1'b0);

      // Single request, dropped after grant, still delivered
      req = 4'b0001;
      tick();
      check_output("single_grant", grant,      4'b0001);
      check_output("single_rngen", rng_enable, 1'b1);
      check_output("single_busy",  busy,       1'b1);
      req = 4'b0000;
      tick();
      check_output("single_rngen_off", rng_enable, 1'b0);
      check_output("single_grant_hold", grant,   4'b0001);
      rng_valid = 1'b1;
      rng_data  = 16'hA5A5;
      tick();
      rng_valid = 1'b0;
      check_output("single_rspv_early", rsp_valid, 4'h0);
      tick();
      check_output("single_rspv", rsp_valid, 4'b0001);
      check_output("single_rspd", rsp_data,  16'hA5A5);
      check_output("single_gclr", grant,     4'h0);
      tick();
      check_output("single_rspv_pulse", rsp_valid, 4'h0);
      check_output("single_rspd_hold",  rsp_data,  16'hA5A5);
      check_output("single_idle_busy",  busy,      1'b0);

      // Serve requester 3 so the pointer wraps back to 0
      transact(4'b1000, 16'h3C3C, 4'b1000, "wrap");

      // All requesting: strict rotation
      transact(4'b1111, 16'h2001, 4'b0001, "rr0");
      transact(4'b1111, 16'h2002, 4'b0010, "rr1");
      transact(4'b1111, 16'h2003, 4'b0100, "rr2");
      transact(4'b1111, 16'h2004, 4'b1000, "rr3");
      transact(4'b1111, 16'h2005, 4'b0001, "rr4");
      req = 4'b0000;
      tick();

      // Three identical words: first two delivered, third trips health
      transact(4'b0001, 16'h1234, 4'b0001, "rep1");
      transact(4'b0001, 16'h1234, 4'b0001, "rep2");
      req = 4'b0001;
      tick();
      check_output("rep3_grant", grant, 4'b0001);
      tick();
      rng_valid = 1'b1;
      rng_data  = 16'h1234;
      tick();
      rng_valid = 1'b0;
      check_output("rep3_hfail", health_fail, 1'b1);
      check_output("rep3_grant_clr", grant,   4'h0);
      check_output("rep3_rspv", rsp_valid,    4'h0);
      tick();
      check_output("rep3_rspv_late", rsp_valid, 4'h0);
      check_output("rep3_busy", busy, 1'b1);
      req = 4'b1111;
      tick();
      tick();
      check_output("fail_req_grant", grant,      4'h0);
      check_output("fail_req_rngen", rng_enable, 1'b0);
      check_output("fail_sticky",    health_fail, 1'b1);

      // Reset out of FAIL (rsp_data was 1234), then wait timeout
      apply_reset("rst1");
      check_output("rst1_state_busy", busy, 1'b0);
      start_warmup();
      feed_words(16'h5000, 0, 16);
      req = 4'b0010;
      tick();
      check_output("to_grant", grant, 4'b0010);
      req = 4'b0000;
      tick();
      for (int i = 0; i < 7; i++) tick();
      check_output("to_before_hfail", health_fail, 1'b0);
      check_output("to_before_grant", grant,       4'b0010);
      tick();
      check_output("to_hfail", health_fail, 1'b1);
      check_output("to_grant_clr", grant,   4'h0);
      check_output("to_busy", busy,         1'b1);

      // Reset during WAIT, then full warmup before next delivery
      apply_reset("rst2");
      start_warmup();
      feed_words(16'h6000, 0, 16);
      req = 4'b0001;
      tick();
      tick();
      tick();
      check_output("w_grant_before", grant, 4'b0001);
      apply_reset("rst3");
      start_warmup();
      feed_words(16'h7000, 0, 15);
      check_output("w_warm15_busy", busy, 1'b1);
      req = 4'b0001;
      feed_words(16'h7000, 15, 1);
      check_output("w_warm_no_grant", grant, 4'h0);
      transact(4'b0001, 16'hBEEF, 4'b0001, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rng_request_arbiter.md
RNG_REQUEST_ARBITER -- requirements
Module: rng_request_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 4, number of requesters; OUTPUT_WIDTH, 16, random word width; WARMUP_WORDS, 16, RNG words discarded after reset; REPEAT_LIMIT, 3, consecutive identical words that declare health failure; TIMEOUT_CYCLES, 8, maximum wait for an RNG word.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req  in  NUM_REQ  per-requester level request for one random word.
REQ-006 grant  out  NUM_REQ  one-hot owner of the current transaction; zero when none.
REQ-007 rsp_valid  out  NUM_REQ  one-cycle pulse to the granted requester when rsp_data is valid.
REQ-008 rsp_data  out  OUTPUT_WIDTH  delivered random word; holds its value between deliveries.
REQ-009 rng_enable  out  1  generate enable to the RNG datapath.
REQ-010 rng_data  in  OUTPUT_WIDTH  RNG output word.
REQ-011 rng_valid  in  1  RNG word-valid strobe.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 health_fail  out  1  sticky failure flag.

Function
REQ-014 The FSM SHALL have the states WARMUP, IDLE, ISSUE, WAIT, DELIVER and FAIL, and all outputs SHALL be registered.
REQ-015 In WARMUP: rng_enable=1; each rng_valid word SHALL be discarded and counted; after WARMUP_WORDS words, rng_enable SHALL drop to 0 and the FSM SHALL go to IDLE.
REQ-016 In IDLE with any req bit set: the block SHALL pick the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), register it to grant, and go to ISSUE; with no req the FSM SHALL stay in IDLE.
REQ-017 In ISSUE: rng_enable SHALL be 1 for exactly one cycle, the wait timer SHALL be cleared, and the FSM SHALL go to WAIT.
REQ-018 In WAIT: rng_enable=0; on rng_valid the block SHALL capture rng_data and go to DELIVER; otherwise the timer SHALL increment, and on reaching TIMEOUT_CYCLES the FSM SHALL go to FAIL.
REQ-019 In DELIVER: rsp_data SHALL take the captured word; rsp_valid SHALL equal grant for one cycle; in the next cycle grant SHALL be 0 and rr_ptr SHALL be set to granted index +1 mod NUM_REQ; the FSM SHALL return to IDLE.
REQ-020 End-to-end latency SHALL be: grant 1 cycle after req is sampled in IDLE; rsp_valid 2 cycles after rng_valid.
REQ-021 A requester dropping req after grant SHALL NOT abort the transaction; the word SHALL still be delivered.
REQ-022 req changes while grant is nonzero SHALL be ignored until the FSM returns to IDLE; at most one transaction SHALL be outstanding.
REQ-023 rng_valid outside WARMUP and WAIT SHALL be ignored.
REQ-024 Health check: every captured word, warmup words included, SHALL be compared with the previous word; a match SHALL increment repeat_cnt, and a mismatch SHALL reset repeat_cnt to 1.
REQ-025 When repeat_cnt reaches REPEAT_LIMIT, the FSM SHALL go to FAIL and that word SHALL NOT be delivered.
REQ-026 In FAIL: health_fail=1, grant=0, rsp_valid=0, rng_enable=0, and req SHALL be ignored; only rst_n SHALL exit FAIL.

Reset
REQ-027 rst_n low SHALL immediately set the state to WARMUP and clear grant, rsp_valid, rsp_data, rng_enable, busy, health_fail, rr_ptr, all counters and the previous-word register, regardless of the current state.
REQ-028 rng_enable SHALL first assert in the first clock after rst_n deasserts; busy SHALL be 1 during WARMUP.

Verification
REQ-029 Reset release, RNG model returns distinct words -> rng_enable high until the 16th rng_valid, no rsp_valid pulse, busy low afterward.
REQ-030 req=4'b0001, rng_data=16'hA5A5 -> grant=0001 next cycle, one-cycle rng_enable pulse, rsp_valid=0001 with rsp_data=16'hA5A5, then grant=0.
REQ-031 req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, one word each.
REQ-032 rng_data=16'h1234 on three consecutive words -> health_fail=1 on the third, no rsp_valid for it, later req ignored.
REQ-033 rng_valid never asserted in WAIT -> FAIL after 8 cycles; health_fail=1; grant=0.
REQ-034 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, WARMUP restarts, and the next delivery follows a full 16-word warmup.
